// File: rtl/pacman_move.sv
// pacman_move: tick-paced sprite stepper with grid-aligned turns and a registered map-probe handshake
module pacman_move #(
  parameter int STEP_MS = 10,
  parameter int START_X = 173,
  parameter int START_Y = 305,
  parameter int HALF    = 11,
  parameter int TILE    = 16,
  parameter int MAX_X   = 346,
  parameter int MAX_Y   = 404
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic [3:0] btn,
  input  logic       map_wall,
  output logic [8:0] qry_x,
  output logic [8:0] qry_y,
  output logic [8:0] p_x,
  output logic [8:0] p_y,
  output logic [1:0] dir,
  output logic       moving
);
  localparam int CW = $clog2(STEP_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_MS - 1);
  localparam logic [8:0] HS  = 9'(HALF);
  localparam logic [8:0] OFF = 9'(HALF + 1);
  localparam logic [8:0] XH  = 9'(MAX_X - HALF);
  localparam logic [8:0] YH  = 9'(MAX_Y - HALF);
  localparam logic [8:0] TL  = 9'(TILE);
  localparam logic [8:0] MID = 9'(TILE / 2);
  typedef enum logic [2:0] {S_WAIT, S_TURN_Q, S_TURN_C, S_MOVE_Q, S_MOVE_C} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] req_dir, pdir, probe_dir, btn_dir;
  logic [8:0] probe_x, probe_y;
  logic req_valid, step_due, step_fire, aligned, rev, oob, free;
  logic ld_q, turn_ok, mv_c;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_WAIT;
    else state <= nxt;
  assign aligned = (p_x % TL) == MID && (p_y % TL) == MID;
  assign rev = req_dir == (dir ^ 2'b01);
  always_comb begin
    nxt = state;
    case (state)
      S_WAIT:   nxt = !step_due ? S_WAIT : (req_valid && req_dir != dir) ? S_TURN_Q : S_MOVE_Q;
      S_TURN_Q: nxt = (rev || aligned) ? S_TURN_C : S_MOVE_Q;
      S_TURN_C: nxt = S_MOVE_Q;
      S_MOVE_Q: nxt = S_MOVE_C;
      default:  nxt = S_WAIT;
    endcase
  end
  // Edge test uses the held probe direction; the centre cannot change between *_Q and *_C.
  assign oob = pdir == 2'd0 ? p_y <= HS :
               pdir == 2'd1 ? p_y >= YH :
               pdir == 2'd2 ? p_x <= HS : p_x >= XH;
  assign free = !oob && !map_wall;
  always_comb begin
    probe_dir = state == S_TURN_Q ? req_dir : dir;
    probe_x = probe_dir == 2'd2 ? (p_x > HS ? p_x - OFF : 9'd0) :
              probe_dir == 2'd3 ? (p_x < XH ? p_x + OFF : p_x) : p_x;
    probe_y = probe_dir == 2'd0 ? (p_y > HS ? p_y - OFF : 9'd0) :
              probe_dir == 2'd1 ? (p_y < YH ? p_y + OFF : p_y) : p_y;
    ld_q = state == S_TURN_Q || state == S_MOVE_Q;
    turn_ok = state == S_TURN_C && free;
    mv_c = state == S_MOVE_C;
    btn_dir = btn[0] ? 2'd0 : btn[1] ? 2'd1 : btn[2] ? 2'd2 : 2'd3;
    step_fire = tick_1ms && cnt == LAST;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p_x <= 9'(START_X);
      p_y <= 9'(START_Y);
      dir <= 2'd2;
      moving <= 1'b0;
      qry_x <= '0;
      qry_y <= '0;
      pdir <= 2'd2;
      req_dir <= 2'd0;
      req_valid <= 1'b0;
      cnt <= '0;
      step_due <= 1'b0;
    end else begin
      if (|btn) begin
        req_dir <= btn_dir;
        req_valid <= 1'b1;
      end else if (turn_ok) req_valid <= 1'b0;
      if (tick_1ms) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (step_fire) step_due <= 1'b1;
      else if (state == S_WAIT) step_due <= 1'b0;
      if (ld_q) begin
        qry_x <= probe_x;
        qry_y <= probe_y;
        pdir <= probe_dir;
      end
      if (turn_ok) dir <= pdir;
      if (mv_c) moving <= free;
      if (mv_c && free) begin
        p_x <= pdir == 2'd2 ? p_x - 9'd1 : pdir == 2'd3 ? p_x + 9'd1 : p_x;
        p_y <= pdir == 2'd0 ? p_y - 9'd1 : pdir == 2'd1 ? p_y + 9'd1 : p_y;
      end
    end
endmodule

// File: tb/tb_pacman_move.sv
// tb_pacman_move: directed checks of stepping, walls, turns, edge clamp and mid-step reset
module tb_pacman_move;
  logic clk = 1'b0, reset = 1'b0, tick_1ms = 1'b0, map_wall = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [8:0] qry_x, qry_y, p_x, p_y;
  logic [1:0] dir;
  logic moving;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  pacman_move #(.START_Y(296)) u_dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .btn(btn), .map_wall(map_wall),
    .qry_x(qry_x), .qry_y(qry_y), .p_x(p_x), .p_y(p_y), .dir(dir), .moving(moving)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int k);
    repeat (k) begin
      @(negedge clk) tick_1ms = 1'b1;
      @(negedge clk) tick_1ms = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask
  task automatic press(input logic [3:0] b);
    @(negedge clk) btn = b;
    @(negedge clk) btn = 4'd0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_px"}, 16'(p_x), 16'd173);
    chk({tag, "_py"}, 16'(p_y), 16'd296);
    chk({tag, "_dir"}, 16'(dir), 16'd2);
    chk({tag, "_mov"}, 16'(moving), 16'd0);
    chk({tag, "_qx"}, 16'(qry_x), 16'd0);
    chk({tag, "_qy"}, 16'(qry_y), 16'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(negedge clk) reset = 1'b1;
    map_wall = 1'b1;
    ticks(10);
    chk("wall_px", 16'(p_x), 16'd173);
    chk("wall_mov", 16'(moving), 16'd0);
    chk("wall_qx", 16'(qry_x), 16'd161);
    chk("wall_qy", 16'(qry_y), 16'd296);
    map_wall = 1'b0;
    ticks(9);
    chk("pre_step_px", 16'(p_x), 16'd173);
    ticks(1);
    chk("step1_px", 16'(p_x), 16'd172);
    chk("step1_mov", 16'(moving), 16'd1);
    ticks(10);
    chk("step2_px", 16'(p_x), 16'd171);
    chk("step2_dir", 16'(dir), 16'd2);
    map_wall = 1'b1;
    ticks(10);
    chk("wall2_px", 16'(p_x), 16'd171);
    chk("wall2_mov", 16'(moving), 16'd0);
    map_wall = 1'b0;
    press(4'b0001);
    ticks(30);
    chk("unal_px", 16'(p_x), 16'd168);
    chk("unal_dir", 16'(dir), 16'd2);
    chk("unal_py", 16'(p_y), 16'd296);
    ticks(10);
    chk("al_dir", 16'(dir), 16'd0);
    chk("al_py", 16'(p_y), 16'd295);
    chk("al_px", 16'(p_x), 16'd168);
    press(4'b0010);
    ticks(10);
    chk("rev_dir", 16'(dir), 16'd1);
    chk("rev_py", 16'(p_y), 16'd296);
    press(4'b1000);
    ticks(10);
    chk("right_dir", 16'(dir), 16'd3);
    chk("right_px", 16'(p_x), 16'd169);
    press(4'b0100);
    ticks(10);
    chk("left_dir", 16'(dir), 16'd2);
    chk("left_px", 16'(p_x), 16'd168);
    press(4'b0011);
    ticks(10);
    chk("prio_dir", 16'(dir), 16'd0);
    chk("prio_py", 16'(p_y), 16'd295);
    chk("prio_px", 16'(p_x), 16'd168);
    ticks(9);
    @(negedge clk) tick_1ms = 1'b1;
    @(negedge clk) tick_1ms = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_reset("mid");
    @(negedge clk) reset = 1'b1;
    ticks(9);
    chk("rel9_px", 16'(p_x), 16'd173);
    ticks(1);
    chk("rel10_px", 16'(p_x), 16'd172);
    chk("rel10_dir", 16'(dir), 16'd2);
    ticks(1610);
    chk("edge_px", 16'(p_x), 16'd11);
    chk("edge_mov", 16'(moving), 16'd1);
    ticks(10);
    chk("clamp_px", 16'(p_x), 16'd11);
    chk("clamp_mov", 16'(moving), 16'd0);
    chk("clamp_py", 16'(p_y), 16'd296);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pacman_move.md
PACMAN_MOVE -- requirements
Module: pacman_move

Interface
REQ-001 Parameter STEP_MS, default 10, meaning 1 ms ticks per one-pixel step.
REQ-002 Parameter START_X, default 173, meaning reset X of the sprite centre in map coordinates.
REQ-003 Parameter START_Y, default 305, meaning reset Y of the sprite centre in map coordinates.
REQ-004 Parameter HALF, default 11, meaning sprite half-width in pixels.
REQ-005 Parameter TILE, default 16, meaning grid pitch used for turn alignment.
REQ-006 Parameter MAX_X, default 346, meaning highest legal map X.
REQ-007 Parameter MAX_Y, default 404, meaning highest legal map Y.
REQ-008 clk  in  1  system clock; the only clock in the block.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 tick_1ms  in  1  one-clk-wide enable pulse once per millisecond.
REQ-011 btn  in  4  active-high requests: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-012 map_wall  in  1  1 = wall at (qry_x, qry_y); valid combinationally in the same cycle the query is driven.
REQ-013 qry_x  out  9  map query X.
REQ-014 qry_y  out  9  map query Y.
REQ-015 p_x  out  9  sprite centre X, consumed by the renderer.
REQ-016 p_y  out  9  sprite centre Y, consumed by the renderer.
REQ-017 dir  out  2  current heading: 0 up, 1 down, 2 left, 3 right.
REQ-018 moving  out  1  1 = the last step attempt succeeded.

Function
REQ-019 Button latch: each clk, any asserted btn bit SHALL load the pending request (req_dir, req_valid=1); on multiple bits, priority is up > down > left > right; with no bit asserted, the request SHALL be held.
REQ-020 Step counter: counts tick_1ms pulses; on the tick where count==STEP_MS-1 it SHALL clear to 0 and set sticky step_due; ticks without clk enable SHALL be ignored.
REQ-021 FSM states: WAIT, TURN_Q, TURN_C, MOVE_Q, MOVE_C; reset state is WAIT.
REQ-022 WAIT: if step_due, clear step_due and go to TURN_Q when req_valid and req_dir!=dir, else go to MOVE_Q.
REQ-023 TURN_Q: if req_dir is the reverse of dir, go to TURN_C; otherwise go to TURN_C only when aligned, i.e. (p_x mod TILE)==TILE/2 and (p_y mod TILE)==TILE/2, else go to MOVE_Q; in all cases drive the probe for req_dir.
REQ-024 Probe for direction d: the point one pixel beyond the leading edge, i.e. centre offset by HALF+1 along d, other axis equal to the centre.
REQ-025 TURN_C: if the probe is free, set dir<=req_dir and clear req_valid; then go to MOVE_Q; if blocked, dir is unchanged and req_valid stays set.
REQ-026 MOVE_Q: drive the probe for dir, then go to MOVE_C.
REQ-027 MOVE_C: if free, advance p_x/p_y by exactly 1 pixel along dir and set moving=1; if blocked, hold position and set moving=0; then go to WAIT.
REQ-028 The probe SHALL count as blocked without consulting map_wall if the next centre would leave [HALF, MAX_X-HALF] in X or [HALF, MAX_Y-HALF] in Y; there is no wrap-around.
REQ-029 All position arithmetic SHALL be unsigned 9-bit, with bounds checked before add/subtract so no underflow occurs.
REQ-030 qry_x/qry_y SHALL be registered and stable through the following *_C state; map_wall SHALL be sampled only in TURN_C and MOVE_C.
REQ-031 A step_due arriving while not in WAIT SHALL be retained and served on the next WAIT; at most one pending step.
REQ-032 p_x, p_y, dir and moving SHALL change only in TURN_C or MOVE_C.

Reset
REQ-033 While reset is low, asynchronously: p_x=START_X, p_y=START_Y, dir=2 (left), moving=0, qry_x=qry_y=0, req_valid=0, step counter=0, step_due=0, state=WAIT.
REQ-034 Reset asserted mid-sequence (any state) SHALL abandon the step with no partial position update; the first step after release SHALL require a full STEP_MS ticks.

Verification
REQ-035 Reset release, map_wall=0, no btn, 20 ticks -> p_x 173 -> 171 (2 steps), dir=2, moving=1.
REQ-036 map_wall=1 always -> p_x stays 173, moving=0 after the first step; qry_x=161 (173-12) in MOVE_C.
REQ-037 btn=4'b0011 pulsed for 1 clk, centre aligned, path free -> dir=0 on the next step, p_y decrements by 1.
REQ-038 btn up while not aligned -> dir stays 2, req_valid held until the first aligned step, then dir=0.
REQ-039 Place the centre at x=HALF moving left, map_wall=0 -> position holds at 11, moving=0, no underflow.
REQ-040 Assert reset in MOVE_Q -> outputs return to REQ-033 values immediately; after release, the first move occurs exactly 10 ticks later.
